// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with a registered
// inter-chunk carry, exchanging operands and results over valid/ready handshakes.
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  opa, opb;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  opa_c [NCHUNK];
  logic [CHUNK-1:0]  opb_c [NCHUNK];
  logic [CHUNK-1:0]  s_c   [NCHUNK];
  logic [CHUNK-1:0]  ca, cb, csum;
  logic              cnext, last, msb_cin;

  // Operands and result viewed as chunk arrays so the per-cycle select is a plain mux.
  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    assign opa_c[g]                 = opa[g*CHUNK +: CHUNK];
    assign opb_c[g]                 = opb[g*CHUNK +: CHUNK];
    assign s[g*CHUNK +: CHUNK]      = s_c[g];
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_comb begin
    ca            = opa_c[idx];
    cb            = opb_c[idx];
    {cnext, csum} = {1'b0, ca} + {1'b0, cb} + (CHUNK+1)'(carry);
    last          = (idx == IDXW'(NCHUNK - 1));
    // Carry into the MSB recovered from the sum bit and its two addend bits.
    msb_cin       = csum[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last)     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      for (int unsigned i = 0; i < NCHUNK; i++) s_c[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
          end
        end
        BUSY: begin
          s_c[idx] <= csum;
          carry    <= cnext;
          idx      <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout <= cnext;
            ovf  <= msb_cin ^ cnext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: directed vector table plus random operands, checked
// against an integer-arithmetic reference across three WIDTH/CHUNK configurations.
`timescale 1ns/1ps
module tb_chunked_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_ready;

  logic        ir0, ov0, co0, of0;
  logic [15:0] s0;
  logic        ir1, ov1, co1, of1;
  logic [15:0] s1;
  logic        ir2, ov2, co2, of2;
  logic [11:0] s2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .s(s0),
    .cout(co0), .ovf(of0));

  chunked_add_sub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .s(s1),
    .cout(co1), .ovf(of1));

  chunked_add_sub #(.WIDTH(12), .CHUNK(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a[11:0]), .b(b[11:0]),
    .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready), .s(s2),
    .cout(co2), .ovf(of2));

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        cout, ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string tag, input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, name, act, exp);
  endtask

  // Reference: exact integer arithmetic, then reduce modulo 2^w and range-check signed.
  function automatic void ref_model(input int w, input logic [15:0] a_i, b_i,
                                    input logic cin_i, sub_i, output logic [15:0] s_o,
                                    output logic cout_o, output logic ovf_o);
    longint md, half, ua, ub, sa, sb, c, u, sr;
    md   = longint'(1) << w;
    half = md / 2;
    ua   = longint'(a_i) & (md - 1);
    ub   = longint'(b_i) & (md - 1);
    c    = longint'(cin_i);
    sa   = (ua >= half) ? ua - md : ua;
    sb   = (ub >= half) ? ub - md : ub;
    if (!sub_i) begin
      u      = ua + ub + c;
      sr     = sa + sb + c;
      cout_o = (u >= md);
    end else begin
      u      = ua - ub - c;
      sr     = sa - sb - c;
      cout_o = (u >= 0);
    end
    s_o   = 16'(u & (md - 1));
    ovf_o = (sr >= half) || (sr < -half);
  endfunction

  task automatic run_op(input string tag, input logic [15:0] av, bv, input logic ci, sb,
                        input bit noise, input int hold, input bit use_exp,
                        input logic [15:0] es, input logic ec, eo);
    logic [15:0] m0s, m1s, m2s;
    logic        m0c, m0o, m1c, m1o, m2c, m2o;
    int          l0, l1, l2;
    ref_model(16, av, bv, ci, sb, m0s, m0c, m0o);
    ref_model(16, av, bv, ci, sb, m1s, m1c, m1o);
    ref_model(12, av, bv, ci, sb, m2s, m2c, m2o);
    if (use_exp) begin
      m0s = es; m0c = ec; m0o = eo;
    end
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
    chk(tag, "in_ready_idle", 16'(ir0), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(tag, "in_ready_after_accept", 16'(ir0), 16'd0);
    l0 = 0; l1 = 0; l2 = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
      end
      @(posedge clk); #1;
      if (ov0 && l0 == 0) l0 = cyc;
      if (ov1 && l1 == 0) l1 = cyc;
      if (ov2 && l2 == 0) l2 = cyc;
      chk(tag, "in_ready_busy", 16'(ir0), 16'd0);
      if (l0 != 0 && l1 != 0 && l2 != 0) break;
    end
    in_valid = 1'b0;
    chk(tag, "lat_16_4",  16'(l0), 16'd4);
    chk(tag, "lat_16_16", 16'(l1), 16'd1);
    chk(tag, "lat_12_3",  16'(l2), 16'd4);
    chk(tag, "s_16_4", s0, m0s);
    chk(tag, "cout_16_4", 16'(co0), 16'(m0c));
    chk(tag, "ovf_16_4", 16'(of0), 16'(m0o));
    chk(tag, "s_16_16", s1, m1s);
    chk(tag, "cout_16_16", 16'(co1), 16'(m1c));
    chk(tag, "ovf_16_16", 16'(of1), 16'(m1o));
    chk(tag, "s_12_3", 16'(s2), m2s);
    chk(tag, "cout_12_3", 16'(co2), 16'(m2c));
    chk(tag, "ovf_12_3", 16'(of2), 16'(m2o));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk(tag, "hold_s", s0, m0s);
      chk(tag, "hold_cout", 16'(co0), 16'(m0c));
      chk(tag, "hold_ovf", 16'(of0), 16'(m0o));
      chk(tag, "hold_out_valid", 16'(ov0), 16'd1);
      chk(tag, "hold_in_ready", 16'(ir0), 16'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(tag, "out_valid_drop", 16'(ov0), 16'd0);
    chk(tag, "in_ready_return", 16'(ir0), 16'd1);
    chk(tag, "out_valid_drop_16_16", 16'(ov1), 16'd0);
    chk(tag, "out_valid_drop_12_3", 16'(ov2), 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    tbl[7] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "in_ready_in_rst", 16'(ir0), 16'd0);
    rst = 1'b0;
    #1;
    chk("reset", "s", s0, 16'h0000);
    chk("reset", "cout", 16'(co0), 16'd0);
    chk("reset", "ovf", 16'(of0), 16'd0);
    chk("reset", "out_valid", 16'(ov0), 16'd0);
    chk("reset", "in_ready", 16'(ir0), 16'd1);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
             1'b0, 0, 1'b1, tbl[i].s, tbl[i].cout, tbl[i].ovf);

    // Backpressure in DONE with operand noise on the inputs during BUSY.
    run_op("backpressure", tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub,
           1'b1, 3, 1'b1, tbl[0].s, tbl[0].cout, tbl[0].ovf);

    // Reset after chunk 2 of 4.
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst", "out_valid", 16'(ov0), 16'd0);
    chk("midrst", "s", s0, 16'h0000);
    chk("midrst", "cout", 16'(co0), 16'd0);
    chk("midrst", "ovf", 16'(of0), 16'd0);
    chk("midrst", "in_ready_in_rst", 16'(ir0), 16'd0);
    chk("midrst", "out_valid_16_16", 16'(ov1), 16'd0);
    chk("midrst", "s_12_3", 16'(s2), 16'h0000);
    rst = 1'b0;
    #1;
    chk("midrst", "in_ready", 16'(ir0), 16'd1);
    @(posedge clk); #1;
    chk("midrst", "out_valid_idle", 16'(ov0), 16'd0);
    run_op("after_rst", tbl[7].a, tbl[7].b, tbl[7].cin, tbl[7].sub,
           1'b0, 0, 1'b1, tbl[7].s, tbl[7].cout, tbl[7].ovf);

    for (int i = 0; i < 40; i++)
      run_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom), (i % 4) == 0, i % 3, 1'b0, 16'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
